// File: rtl/dmem_if.sv
// dmem_if: request/response bus between the MEM stage and dmem_bank
interface dmem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [2:0]  funct3;
  logic [31:0] wdata;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic        busy;
  modport master (output req, we, addr, funct3, wdata, input ready, rvalid, rdata, err, busy);
  modport slave (input req, we, addr, funct3, wdata, output ready, rvalid, rdata, err, busy);
endinterface

// File: rtl/dmem_bank.sv
// dmem_bank: byte-addressed RISC-V data memory with one-cycle registered read.
// DMEM_CLEAR_ON_RESET_EN adds a zeroing sweep of the array after every reset.
module dmem_bank #(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);
  logic [31:0]      mem [DEPTH];
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic [2:0]       f3;
  logic             acc, oor, ill, mis, e, wr;
  logic [31:0]      w, ld, sd;
  logic [7:0]       b;
  logic [15:0]      h;
  logic [3:0]       be;
  assign idx  = bus.addr[IDX_W+1:2];
  assign lane = bus.addr[1:0];
  assign f3   = bus.funct3;
  assign oor  = |bus.addr[31:IDX_W+2];
  assign ill  = bus.we ? (f3 > 3'd2) : (f3[1:0] == 2'b11 || f3 == 3'b110);
  assign mis  = (f3[1:0] == 2'd1 && bus.addr[0]) || (f3[1:0] == 2'd2 && lane != 2'd0);
  assign e    = oor || ill || mis;
  assign acc  = bus.req && bus.ready && !rst;
  assign wr   = acc && bus.we && !e;
  assign w    = mem[idx];
  always_comb begin
    b  = w[{lane, 3'b000} +: 8];
    h  = lane[1] ? w[31:16] : w[15:0];
    ld = f3[1:0] == 2'd0 ? {{24{~f3[2] & b[7]}}, b} :
         f3[1:0] == 2'd1 ? {{16{~f3[2] & h[15]}}, h} : w;
    sd = f3[1:0] == 2'd0 ? {4{bus.wdata[7:0]}} :
         f3[1:0] == 2'd1 ? {2{bus.wdata[15:0]}} : bus.wdata;
    be = f3[1:0] == 2'd0 ? 4'b0001 << lane :
         f3[1:0] == 2'd1 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  end
`ifdef DMEM_CLEAR_ON_RESET_EN
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t           state, state_nx;
  logic [IDX_W-1:0] cnt, cnt_nx;
  always_ff @(posedge clk) begin
    state <= rst ? CLEAR : state_nx;
    cnt   <= rst ? '0 : cnt_nx;
  end
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (state == CLEAR) begin
      cnt_nx   = cnt + 1'b1;
      state_nx = &cnt ? IDLE : CLEAR;
    end
  end
  assign bus.ready = state == IDLE;
  assign bus.busy  = state == CLEAR;
  always_ff @(posedge clk) begin
    if (bus.busy && !rst) mem[cnt] <= '0;
    else if (wr)
      for (int i = 0; i < 4; i++) if (be[i]) mem[idx][8*i +: 8] <= sd[8*i +: 8];
  end
`else
  logic ready_r;
  always_ff @(posedge clk) ready_r <= !rst;
  assign bus.ready = ready_r;
  assign bus.busy  = 1'b0;
  always_ff @(posedge clk) begin
    if (wr)
      for (int i = 0; i < 4; i++) if (be[i]) mem[idx][8*i +: 8] <= sd[8*i +: 8];
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rvalid <= 1'b0;
      bus.rdata  <= '0;
      bus.err    <= 1'b0;
    end else begin
      bus.rvalid <= acc;
      bus.err    <= acc && e;
      bus.rdata  <= (acc && !bus.we && !e) ? ld : '0;
    end
  end
endmodule
